// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and encodings for the multicycle RV64 control unit.
package ctrl_pkg;

  // Controller states; the encoding is what state_dbg exposes.
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    ALU_WB   = 4'd7,
    MEM_WB   = 4'd8,
    BRANCH   = 4'd9,
    PC_INC   = 4'd10,
    HALT     = 4'd11,
    TRAP     = 4'd12
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b001,
    ALU_SUB = 3'b010,
    ALU_AND = 3'b011,
    ALU_OR  = 3'b100,
    ALU_XOR = 3'b101
  } alu_op_e;

  // Instruction class chosen by the opcode alone.
  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_MEM,
    CLS_BRANCH,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_e;

  // Everything the FSM needs to know about the latched instruction.
  typedef struct packed {
    op_class_e op_class;
    alu_op_e   alu_op;
    logic      illegal;
    logic      is_store;
    logic      is_bne;
  } decode_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  localparam logic [2:0] F3_ADD    = 3'b000;
  localparam logic [2:0] F3_AND    = 3'b111;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_DOUBLE = 3'b011;
  localparam logic [2:0] F3_BEQ    = 3'b000;
  localparam logic [2:0] F3_BNE    = 3'b001;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_SUB  = 7'h20;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational classification of the latched instruction word.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] instruction,
  output decode_t     dec
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];

  // Map opcode/funct fields to class, ALU operation and legality.
  always_comb begin
    dec.op_class = CLS_ILLEGAL;
    dec.alu_op   = ALU_ADD;
    dec.illegal  = 1'b1;
    dec.is_store = 1'b0;
    dec.is_bne   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec.op_class = CLS_R;
        if (funct7 == F7_BASE) begin
          case (funct3)
            F3_ADD: begin dec.alu_op = ALU_ADD; dec.illegal = 1'b0; end
            F3_AND: begin dec.alu_op = ALU_AND; dec.illegal = 1'b0; end
            F3_OR:  begin dec.alu_op = ALU_OR;  dec.illegal = 1'b0; end
            F3_XOR: begin dec.alu_op = ALU_XOR; dec.illegal = 1'b0; end
            default: ;
          endcase
        end else if (funct7 == F7_SUB && funct3 == F3_ADD) begin
          dec.alu_op  = ALU_SUB;
          dec.illegal = 1'b0;
        end
      end
      OP_ITYPE: begin
        dec.op_class = CLS_I;
        case (funct3)
          F3_ADD: begin dec.alu_op = ALU_ADD; dec.illegal = 1'b0; end
          F3_AND: begin dec.alu_op = ALU_AND; dec.illegal = 1'b0; end
          F3_OR:  begin dec.alu_op = ALU_OR;  dec.illegal = 1'b0; end
          F3_XOR: begin dec.alu_op = ALU_XOR; dec.illegal = 1'b0; end
          default: ;
        endcase
      end
      OP_LOAD, OP_STORE: begin
        dec.op_class = CLS_MEM;
        dec.illegal  = (funct3 != F3_DOUBLE);
        dec.is_store = (opcode == OP_STORE);
      end
      OP_BRANCH: begin
        dec.op_class = CLS_BRANCH;
        dec.alu_op   = ALU_SUB;
        dec.illegal  = !(funct3 == F3_BEQ || funct3 == F3_BNE);
        dec.is_bne   = (funct3 == F3_BNE);
      end
      OP_SYSTEM: begin
        if (instruction == INSTR_EBREAK) begin
          dec.op_class = CLS_HALT;
          dec.illegal  = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multicycle RV64 core.
// Optional feature: CTRL_ILLEGAL_TRAP_EN sends illegal encodings to a terminal
// TRAP state and adds the sticky illegal_instr output; otherwise they act as NOPs.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int IMEM_LAT = 1,
  parameter int DMEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] instruction,
  input  logic        alu_zero,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        PCSource,
  output logic        ALUSrcA,
  output logic        LoadAOut,
  output logic        RegWrite,
  output logic        LoadRegA,
  output logic        LoadRegB,
  output logic        MemToReg,
  output logic        DMemOp,
  output logic        LoadMDR,
  output logic        IMemRead,
  output logic        IRWrite,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUOp,
  output logic        halted,
  output logic [31:0] retire_cnt,
  output logic [3:0]  state_dbg
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic        illegal_instr
`endif
);

  localparam int MAX_LAT = (IMEM_LAT > DMEM_LAT) ? IMEM_LAT : DMEM_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] IMEM_LAST = CNT_W'(IMEM_LAT);
  localparam logic [CNT_W-1:0] DMEM_LAST = CNT_W'(DMEM_LAT - 1);

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam state_e ILLEGAL_NEXT = TRAP;
`else
  localparam state_e ILLEGAL_NEXT = PC_INC;
`endif

  state_e           state, next_state;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             retire_inc;
  logic             pc_inc;
  decode_t          dec;

  ctrl_decode u_decode (
    .instruction (instruction),
    .dec         (dec)
  );

  assign state_dbg = state;

  // Next-state, wait counter and Moore flag decode; all flags held low during reset.
  always_comb begin
    next_state  = state;
    cnt_next    = '0;
    retire_inc  = 1'b0;
    pc_inc      = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 1'b0;
    ALUSrcA     = 1'b0;
    LoadAOut    = 1'b0;
    RegWrite    = 1'b0;
    LoadRegA    = 1'b0;
    LoadRegB    = 1'b0;
    MemToReg    = 1'b0;
    DMemOp      = 1'b0;
    LoadMDR     = 1'b0;
    IMemRead    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcB     = SRCB_REGB;
    ALUOp       = ALU_ADD;
    if (reset) begin
      case (state)
        FETCH: begin
          if (cnt != '0 || run) begin
            IMemRead = 1'b1;
            if (cnt == IMEM_LAST) begin
              IRWrite    = 1'b1;
              next_state = DECODE;
            end else begin
              cnt_next = cnt + 1'b1;
            end
          end
        end
        DECODE: begin
          LoadRegA = 1'b1;
          LoadRegB = 1'b1;
          ALUSrcB  = SRCB_IMM2;
          LoadAOut = 1'b1;
          case (dec.op_class)
            CLS_R:      next_state = EXEC_R;
            CLS_I:      next_state = EXEC_I;
            CLS_MEM:    next_state = MEM_ADDR;
            CLS_BRANCH: next_state = BRANCH;
            CLS_HALT:   next_state = HALT;
            default:    next_state = ILLEGAL_NEXT;
          endcase
        end
        EXEC_R: begin
          ALUSrcA    = 1'b1;
          LoadAOut   = 1'b1;
          ALUOp      = dec.alu_op;
          next_state = dec.illegal ? ILLEGAL_NEXT : ALU_WB;
        end
        EXEC_I: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = SRCB_IMM;
          LoadAOut   = 1'b1;
          ALUOp      = dec.alu_op;
          next_state = dec.illegal ? ILLEGAL_NEXT : ALU_WB;
        end
        MEM_ADDR: begin
          ALUSrcA  = 1'b1;
          ALUSrcB  = SRCB_IMM;
          LoadAOut = 1'b1;
          if (dec.illegal)
            next_state = ILLEGAL_NEXT;
          else
            next_state = dec.is_store ? MEM_WR : MEM_RD;
        end
        MEM_RD: begin
          if (cnt == DMEM_LAST) begin
            LoadMDR    = 1'b1;
            next_state = MEM_WB;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        MEM_WR: begin
          DMemOp     = 1'b1;
          pc_inc     = 1'b1;
          retire_inc = 1'b1;
          next_state = FETCH;
        end
        ALU_WB: begin
          RegWrite   = 1'b1;
          pc_inc     = 1'b1;
          retire_inc = 1'b1;
          next_state = FETCH;
        end
        MEM_WB: begin
          RegWrite   = 1'b1;
          MemToReg   = 1'b1;
          pc_inc     = 1'b1;
          retire_inc = 1'b1;
          next_state = FETCH;
        end
        BRANCH: begin
          ALUSrcA  = 1'b1;
          ALUOp    = ALU_SUB;
          PCSource = 1'b1;
          if (dec.illegal) begin
            next_state = ILLEGAL_NEXT;
          end else if (dec.is_bne) begin
            PCWrite    = !alu_zero;
            next_state = alu_zero ? PC_INC : FETCH;
          end else begin
            PCWriteCond = 1'b1;
            next_state  = alu_zero ? FETCH : PC_INC;
          end
          retire_inc = (next_state == FETCH);
        end
        PC_INC: begin
          pc_inc     = 1'b1;
          retire_inc = 1'b1;
          next_state = FETCH;
        end
        HALT:    next_state = HALT;
        TRAP:    next_state = TRAP;
        default: next_state = FETCH;
      endcase
      if (pc_inc) begin
        ALUSrcA  = 1'b0;
        ALUSrcB  = SRCB_FOUR;
        ALUOp    = ALU_ADD;
        PCSource = 1'b0;
        PCWrite  = 1'b1;
      end
    end
  end

  // State register, wait counter, sticky halt and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= FETCH;
      cnt        <= '0;
      halted     <= 1'b0;
      retire_cnt <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      if (next_state == HALT)
        halted <= 1'b1;
      if (retire_inc)
        retire_cnt <= retire_cnt + 32'd1;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  // Sticky flag raised when an illegal encoding sends the core to TRAP.
  always_ff @(posedge clk) begin
    if (!reset)
      illegal_instr <= 1'b0;
    else if (next_state == TRAP)
      illegal_instr <= 1'b1;
  end
`endif

endmodule
